// File: rtl/uart_pkg.sv
// Shared types and constants for the scheduled UART transmitter.
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_pkg;

  localparam int         SAMPLE_RATE_DEF = 16;
  localparam int         DATA_BITS       = 8;
  localparam logic [3:0] UBRR_RESET      = 4'b0100;  // 115200 baud

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } uart_state_e;

endpackage

// File: rtl/rr_arbiter4.sv
// Four-way round-robin selector: the search starts one past the last grant and wraps,
// so the last granted requester has the lowest priority.
module rr_arbiter4 (
  input  logic [3:0] i_req,
  input  logic [1:0] i_last,
  output logic [3:0] o_sel
);

  logic [1:0] w_idx;

  // Walk from the farthest candidate to the nearest; the nearest hit overwrites.
  always_comb begin
    o_sel = 4'b0000;
    w_idx = 2'd0;
    for (int k = 4; k >= 1; k--) begin
      w_idx = i_last + 2'(k);
      if (i_req[w_idx]) begin
        o_sel        = 4'b0000;
        o_sel[w_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Shared UART transmitter: round-robin grant among four byte sources, 8N1 framing
// (8E1 when UART_TX_PARITY_EN is defined), baud-select changes deferred to IDLE.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int SAMPLE_RATE = SAMPLE_RATE_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tick,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic                 cfg_wr,
  input  logic [3:0]           cfg_ubrr,
  output logic [3:0]           ubrr_out,
  output logic                 txd,
  output logic                 busy,
  output logic [1:0]           grant_id,
  output uart_state_e          dbg_state
);

  // Handshake: a byte moves on any edge where req_valid[i] & req_ready[i]; requesters
  // hold valid/data stable until then and never derive valid from ready.
  uart_state_e r_state;
  logic [3:0]  r_tick_cnt;
  logic [2:0]  r_bit_idx;
  logic [7:0]  r_data;
  logic        r_pend;
  logic [3:0]  r_pend_code;

  logic [3:0]  w_sel;
  logic [1:0]  w_sel_id;
  logic [7:0]  w_byte;
  logic        w_can_grant;
  logic        w_fire;
  logic        w_bit_done;

  rr_arbiter4 u_arb (
    .i_req  (req_valid),
    .i_last (grant_id),
    .o_sel  (w_sel)
  );

  always_comb begin
    w_sel_id = 2'd0;
    case (w_sel)
      4'b0010: w_sel_id = 2'd1;
      4'b0100: w_sel_id = 2'd2;
      4'b1000: w_sel_id = 2'd3;
      default: w_sel_id = 2'd0;
    endcase
  end

  // A config write, current or pending, takes the IDLE slot ahead of any grant.
  assign w_can_grant = (r_state == IDLE) && !r_pend && !cfg_wr;
  assign req_ready   = w_can_grant ? w_sel : '0;
  assign w_fire      = |(req_valid & req_ready);
  assign w_byte      = req_data[{w_sel_id, 3'b000} +: 8];
  assign w_bit_done  = tick && (r_tick_cnt == 4'(SAMPLE_RATE - 1));
  assign dbg_state   = r_state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      txd         <= 1'b1;
      busy        <= 1'b0;
      grant_id    <= 2'd3;
      ubrr_out    <= UBRR_RESET;
      r_pend      <= 1'b0;
      r_pend_code <= 4'd0;
      r_tick_cnt  <= 4'd0;
      r_bit_idx   <= 3'd0;
      r_data      <= 8'd0;
    end else begin
      if (cfg_wr) begin
        r_pend      <= 1'b1;
        r_pend_code <= cfg_ubrr;
      end
      // Ticks only matter inside a frame; each bit boundary restarts the count.
      if (r_state != IDLE && tick)
        r_tick_cnt <= w_bit_done ? 4'd0 : r_tick_cnt + 4'd1;

      case (r_state)
        IDLE: begin
          if (r_pend) begin
            ubrr_out <= r_pend_code;
            if (!cfg_wr) r_pend <= 1'b0;
          end else if (w_fire) begin
            r_data     <= w_byte;
            grant_id   <= w_sel_id;
            r_state    <= START;
            txd        <= 1'b0;
            busy       <= 1'b1;
            r_tick_cnt <= 4'd0;
          end
        end
        START: begin
          if (w_bit_done) begin
            r_state   <= DATA;
            r_bit_idx <= 3'd0;
            txd       <= r_data[0];
          end
        end
        DATA: begin
          if (w_bit_done) begin
            if (r_bit_idx == 3'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
              r_state <= PARITY;
              txd     <= ^r_data;
`else
              r_state <= STOP;
              txd     <= 1'b1;
`endif
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
              txd       <= r_data[3'(r_bit_idx + 3'd1)];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (w_bit_done) begin
            r_state <= STOP;
            txd     <= 1'b1;
          end
        end
`endif
        STOP: begin
          if (w_bit_done) begin
            r_state <= IDLE;
            busy    <= 1'b0;
            txd     <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          busy    <= 1'b0;
          txd     <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: directed frames, round-robin order, deferred baud change,
// config-vs-grant priority and mid-frame reset; parity frames when UART_TX_PARITY_EN is set.
module tb_uart_tx_sched;
  import uart_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        tick;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        cfg_wr;
  logic [3:0]  cfg_ubrr;
  logic [3:0]  ubrr_out;
  logic        txd;
  logic        busy;
  logic [1:0]  grant_id;
  uart_state_e dbg_state;

  int errors = 0;
  int checks = 0;

  // Expected frames: [10]=parity bit, [9:8]=grant id, [7:0]=byte
  logic [10:0] exp_q[$];
  logic [7:0]  src_q[4][$];
  int          tph = 0;
  logic [3:0]  prev_ready = 4'b0000;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  uart_tx_sched #(.NUM_REQ(4), .SAMPLE_RATE(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .tick      (tick),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .cfg_wr    (cfg_wr),
    .cfg_ubrr  (cfg_ubrr),
    .ubrr_out  (ubrr_out),
    .txd       (txd),
    .busy      (busy),
    .grant_id  (grant_id),
    .dbg_state (dbg_state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_n(input int n, inout logic ab);
    if (ab) return;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (reset) begin
        ab = 1'b1;
        return;
      end
    end
  endtask

  task automatic wait_state(input uart_state_e s, input int budget, input string name);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < budget && !hit; k++) begin
      @(negedge clk);
      if (dbg_state == s) hit = 1'b1;
    end
    check(name, hit, 1);
  endtask

  task automatic wait_done(input int budget, input string name);
    logic done;
    done = 1'b0;
    for (int k = 0; k < budget && !done; k++) begin
      @(negedge clk);
      if (!busy && exp_q.size() == 0 && src_q[0].size() == 0 && src_q[1].size() == 0 &&
          src_q[2].size() == 0 && src_q[3].size() == 0)
        done = 1'b1;
    end
    check(name, done, 1);
  endtask

  // ---------------- tick generator + requester driver ----------------
  initial begin : drive_proc
    tick      = 1'b0;
    req_valid = 4'b0000;
    req_data  = 32'd0;
    forever begin
      @(negedge clk);
      tick = (tph == 3);
      tph  = (tph + 1) % 4;
      for (int i = 0; i < 4; i++) begin
        if (prev_ready[i] && src_q[i].size() != 0) void'(src_q[i].pop_front());
        req_valid[i]       = (src_q[i].size() != 0);
        req_data[8*i +: 8] = req_valid[i] ? src_q[i][0] : 8'h00;
      end
      #1;
      if (req_ready != 4'b0000) begin
        check("ready_onehot", $onehot(req_ready), 1);
        check("ready_single_pulse", prev_ready, 0);
      end
      prev_ready = reset ? 4'b0000 : req_ready;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin : monitor
    logic        prev, ab, st, sp, pb;
    logic [7:0]  b;
    logic [1:0]  g;
    logic [10:0] e;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev = 1'b1;
      end else if (prev && !txd) begin
        ab = 1'b0; b = 8'd0; pb = 1'b0; sp = 1'b0; st = 1'b1; g = 2'd0;
        wait_n(31, ab);
        st = txd;
        g  = grant_id;
        for (int k = 0; k < 8; k++) begin
          wait_n(64, ab);
          b[k] = txd;
        end
`ifdef UART_TX_PARITY_EN
        wait_n(64, ab);
        pb = txd;
`endif
        wait_n(64, ab);
        sp = txd;
        if (!ab) begin
          check("frame_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("frame_start_bit", st, 0);
            check("frame_data", b, e[7:0]);
            check("frame_grant_id", g, e[9:8]);
            check("frame_stop_bit", sp, 1);
`ifdef UART_TX_PARITY_EN
            check("frame_parity", pb, e[10]);
`endif
          end
        end
        prev = 1'b1;
      end else begin
        prev = txd;
      end
    end
  end

  // ---------------- directed sequence ----------------
  initial begin : main
    int         n;
    logic       hit;
    logic [3:0] bad;
    reset    = 1'b1;
    cfg_wr   = 1'b0;
    cfg_ubrr = 4'h0;
    repeat (3) @(negedge clk);
    check("reset_txd", txd, 1);
    check("reset_busy", busy, 0);
    check("reset_ready", req_ready, 0);
    check("reset_grant_id", grant_id, 3);
    check("reset_ubrr", ubrr_out, 4'h4);
    check("reset_state", dbg_state, IDLE);
    reset = 1'b0;

    // 0xA5 from req0, grant aligned with a tick edge so every bit is exactly 64 clocks
    @(posedge clk);
    while (tph != 3) @(posedge clk);
    src_q[0].push_back(8'hA5);
    exp_q.push_back({1'b0, 2'd0, 8'hA5});
    hit = 1'b0;
    for (int k = 0; k < 20 && !hit; k++) begin
      @(negedge clk);
      if (busy) hit = 1'b1;
    end
    check("a5_grant_seen", hit, 1);
    check("a5_start_low", txd, 0);
    n = 1;
    while (busy && n < 3000) begin
      @(negedge clk);
      if (busy) n++;
    end
    check("a5_busy_len", n, 640);
    wait_done(200, "a5_done");

    // All four requesters valid after reset: order 0,1,2,3,0
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    @(posedge clk);
    src_q[0].push_back(8'h11); src_q[0].push_back(8'h55);
    src_q[1].push_back(8'h22);
    src_q[2].push_back(8'h33);
    src_q[3].push_back(8'h44);
    exp_q.push_back({1'b0, 2'd0, 8'h11});
    exp_q.push_back({1'b0, 2'd1, 8'h22});
    exp_q.push_back({1'b0, 2'd2, 8'h33});
    exp_q.push_back({1'b0, 2'd3, 8'h44});
    exp_q.push_back({1'b0, 2'd0, 8'h55});
    wait_done(6000, "rr_done");

    // Baud change during DATA is deferred until IDLE
    @(posedge clk);
    src_q[2].push_back(8'h5A);
    exp_q.push_back({1'b0, 2'd2, 8'h5A});
    wait_state(DATA, 300, "cfg_reach_data");
    @(negedge clk); cfg_wr = 1'b1; cfg_ubrr = 4'h0;
    @(negedge clk); cfg_wr = 1'b0;
    bad = 4'h4;
    n   = 0;
    while (busy && n < 1000) begin
      @(negedge clk);
      n++;
      if (busy && ubrr_out !== 4'h4) bad = ubrr_out;
    end
    check("cfg_frame_end", busy, 0);
    check("ubrr_midframe", bad, 4'h4);
    check("ubrr_first_idle", ubrr_out, 4'h4);
    @(negedge clk);
    check("ubrr_after_idle", ubrr_out, 4'h0);
    wait_done(200, "cfg_done");

    // cfg_wr and req2 in the same IDLE cycle: config first, grant one cycle later
    @(posedge clk);
    src_q[2].push_back(8'hC3);
    exp_q.push_back({1'b0, 2'd2, 8'hC3});
    @(negedge clk); cfg_wr = 1'b1; cfg_ubrr = 4'h9;
    #1 check("cfg_blocks_ready", req_ready, 0);
    @(negedge clk); cfg_wr = 1'b0;
    #1 check("pending_blocks_ready", req_ready, 0);
    check("ubrr_not_yet", ubrr_out, 4'h0);
    @(negedge clk);
    #1 check("ubrr_updated", ubrr_out, 4'h9);
    check("ready_after_cfg", req_ready, 4'b0100);
    wait_done(1000, "cfg_grant_done");

    // Reset mid-DATA aborts the frame; req1 then sends 0x3C
    @(posedge clk);
    src_q[0].push_back(8'h96);
    wait_state(DATA, 300, "rst_reach_data");
    repeat (100) @(negedge clk);
    reset = 1'b1;
    #1 check("rst_txd_high", txd, 1);
    check("rst_busy_low", busy, 0);
    check("rst_state_idle", dbg_state, IDLE);
    check("rst_grant_id", grant_id, 3);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    src_q[1].push_back(8'h3C);
    exp_q.push_back({1'b0, 2'd1, 8'h3C});
    wait_done(1000, "after_rst_done");

`ifdef UART_TX_PARITY_EN
    @(posedge clk);
    src_q[3].push_back(8'h07);
    src_q[3].push_back(8'h03);
    exp_q.push_back({1'b1, 2'd3, 8'h07});
    exp_q.push_back({1'b0, 2'd3, 8'h03});
    wait_done(2000, "parity_done");
`endif

    check("exp_q_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
